// File: rtl/fifo_umbral_pkg.sv
// Shared constants for the threshold FIFO: default geometry, reset thresholds,
// threshold width and the clamp applied to incoming thresholds.
package fifo_umbral_pkg;

  localparam int DEF_DATA_WIDTH = 6;
  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_ALTO       = 6;
  localparam int DEF_BAJO       = 2;
  localparam int UMBRAL_W       = 4;
  localparam int FIFO_DEPTH     = 1 << DEF_ADDR_WIDTH;

  // Per-cycle occupancy change, derived from the accepted push/pop pair
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Thresholds above the depth can never be reached, so they saturate at it
  function automatic logic [UMBRAL_W-1:0] clamp_umbral(input logic [UMBRAL_W-1:0] v);
    logic [UMBRAL_W-1:0] lim;
    lim = UMBRAL_W'(FIFO_DEPTH);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/fifo_umbral_if.sv
// Write/read handshake bundle of the threshold FIFO; master is the traffic
// source/sink, slave is the FIFO itself.
interface fifo_umbral_if #(
  parameter int DATA_WIDTH = 6
);
  logic                  push;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;

  modport master (
    output push, data_in, pop,
    input  data_out, valid_out
  );

  modport slave (
    input  push, data_in, pop,
    output data_out, valid_out
  );
endinterface

// File: rtl/fifo_umbral_memoria_fifo.sv
// Storage for the threshold FIFO: register array with a synchronous write port
// and a registered, enabled read port. Contents survive reset; the read register does not.
module memoria_fifo #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] rd_data_d;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Read sees the pre-write contents, so a full FIFO doing push+pop on the
  // same slot still returns the oldest entry.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_umbral.sv
// Synchronous FIFO with latched almost-full/almost-empty thresholds and a
// sticky overflow/underflow flag; all status outputs decode registered state.
module fifo_umbral
  import fifo_umbral_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ALTO_DEF   = DEF_ALTO,
  parameter int BAJO_DEF   = DEF_BAJO
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init,
  input  logic [UMBRAL_W-1:0] umbral_alto,
  input  logic [UMBRAL_W-1:0] umbral_bajo,
  fifo_umbral_if.slave        bus,
  output logic                fifo_empty,
  output logic                fifo_full,
  output logic                almost_full,
  output logic                almost_empty,
  output logic                fifo_error,
  output logic [ADDR_WIDTH:0] count
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [CNT_W-1:0]    DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [UMBRAL_W-1:0] ALTO_RST = clamp_umbral(UMBRAL_W'(ALTO_DEF));
  localparam logic [UMBRAL_W-1:0] BAJO_RST = clamp_umbral(UMBRAL_W'(BAJO_DEF));

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [UMBRAL_W-1:0]   alto_q, alto_d;
  logic [UMBRAL_W-1:0]   bajo_q, bajo_d;
  logic                  valid_q, valid_d;
  logic                  error_q, error_d;

  logic                  empty_w;
  logic                  full_w;
  logic                  pop_ok;
  logic                  push_ok;
  logic                  overflow;
  logic                  underflow;
  fifo_op_e              op;
  logic [DATA_WIDTH-1:0] rd_data;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == DEPTH_C);

  // A pop frees a slot in the same edge, so a full FIFO still takes a push alongside it
  always_comb begin
    pop_ok    = bus.pop && !empty_w;
    push_ok   = bus.push && (!full_w || pop_ok);
    overflow  = bus.push && full_w && !bus.pop;
    underflow = bus.pop && empty_w;
    op        = fifo_op_e'({pop_ok, push_ok});
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case (op)
      OP_PUSH: count_d = count_q + 1'b1;
      OP_POP:  count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    alto_d  = alto_q;
    bajo_d  = bajo_q;
    valid_d = pop_ok;
    error_d = error_q || overflow || underflow;
    if (init) begin
      alto_d = clamp_umbral(umbral_alto);
      bajo_d = clamp_umbral(umbral_bajo);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      alto_q   <= ALTO_RST;
      bajo_q   <= BAJO_RST;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      alto_q   <= alto_d;
      bajo_q   <= bajo_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  memoria_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_memoria (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr_q),
    .wr_data (bus.data_in),
    .rd_en   (pop_ok),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  assign bus.data_out  = rd_data;
  assign bus.valid_out = valid_q;

  assign fifo_empty   = empty_w;
  assign fifo_full    = full_w;
  assign almost_full  = (count_q >= alto_q);
  assign almost_empty = (count_q <= bajo_q);
  assign fifo_error   = error_q;
  assign count        = count_q;

endmodule
